// File: rtl/ex_core_mbist.sv
// March C- memory BIST controller driving a single-port RAM with registered pin outputs.
// Define EX_CORE_MBIST_DIAG_EN to run to completion on mismatches and expose fail_count.
module ex_core_mbist #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              CoreIN_CLK,
    input  logic              CoreIN_RESET,
    input  logic              bist_start,
    input  logic [DATA_W-1:0] CoreIN_DOUT,
    output logic              Read,
    output logic              Write,
    output logic [ADDR_W-1:0] CoreIN_ADDR,
    output logic [DATA_W-1:0] CoreIN_DIN,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] fail_addr,
`ifdef EX_CORE_MBIST_DIAG_EN
    output logic [DATA_W-1:0] fail_data,
    output logic [7:0]        fail_count
`else
    output logic [DATA_W-1:0] fail_data
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ONES = {DATA_W{1'b1}};

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_elem, w_elem_nxt;
    logic              r_sub, w_sub_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_last, w_last_nxt;
    logic              r_rd_pend, w_rd_pend_nxt;
    logic              r_exp_bg, w_exp_bg_nxt;
    logic              r_read, w_read_nxt;
    logic              r_write, w_write_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_din, w_din_nxt;
    logic              r_done, w_done_nxt;
    logic              r_fail, w_fail_nxt;
    logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_nxt;
    logic [DATA_W-1:0] r_fail_data, w_fail_data_nxt;
`ifdef EX_CORE_MBIST_DIAG_EN
    logic [7:0]        r_fail_count, w_fail_count_nxt;
`endif

    logic              w_op_rd, w_rd_bg, w_wr_bg, w_sub_last, w_down, w_mismatch, w_abort;
    logic [ADDR_W-1:0] w_end_addr;
    logic [2:0]        w_elem_inc;

    // Decode the current March element/sub-op and check the read that is on the pins
    always_comb begin
        w_op_rd    = (r_elem != 3'd0) && !r_sub;
        w_rd_bg    = (r_elem == 3'd2) || (r_elem == 3'd4);
        w_wr_bg    = (r_elem == 3'd1) || (r_elem == 3'd3);
        w_sub_last = (r_elem == 3'd0) || (r_elem == 3'd5) || r_sub;
        w_down     = (r_elem >= 3'd3);
        w_end_addr = w_down ? ADDR_ZERO : ADDR_MAX;
        w_elem_inc = r_elem + 3'd1;
        w_mismatch = r_rd_pend && (CoreIN_DOUT != (r_exp_bg ? DATA_ONES : DATA_ZERO));
    end

`ifdef EX_CORE_MBIST_DIAG_EN
    assign w_abort = 1'b0;
`else
    assign w_abort = w_mismatch;
`endif

    // Next-state, pin and result logic; pins fall back to idle unless an op is issued
    always_comb begin
        w_state_nxt     = r_state;
        w_elem_nxt      = r_elem;
        w_sub_nxt       = r_sub;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_rd_pend_nxt   = 1'b0;
        w_exp_bg_nxt    = r_exp_bg;
        w_read_nxt      = 1'b1;
        w_write_nxt     = 1'b0;
        w_addr_nxt      = ADDR_ZERO;
        w_din_nxt       = DATA_ZERO;
        w_done_nxt      = r_done;
        w_fail_nxt      = r_fail;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_data_nxt = r_fail_data;
`ifdef EX_CORE_MBIST_DIAG_EN
        w_fail_count_nxt = r_fail_count;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    w_state_nxt     = ST_RUN;
                    w_elem_nxt      = 3'd0;
                    w_sub_nxt       = 1'b0;
                    w_cnt_nxt       = ADDR_ZERO;
                    w_last_nxt      = 1'b0;
                    w_done_nxt      = 1'b0;
                    w_fail_nxt      = 1'b0;
                    w_fail_addr_nxt = ADDR_ZERO;
                    w_fail_data_nxt = DATA_ZERO;
`ifdef EX_CORE_MBIST_DIAG_EN
                    w_fail_count_nxt = 8'd0;
`endif
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (w_mismatch && !r_fail) begin
                    w_fail_nxt      = 1'b1;
                    w_fail_addr_nxt = r_addr;
                    w_fail_data_nxt = CoreIN_DOUT;
                end else begin
                    w_fail_nxt = r_fail;
                end
`ifdef EX_CORE_MBIST_DIAG_EN
                if (w_mismatch && (r_fail_count != 8'd255)) begin
                    w_fail_count_nxt = r_fail_count + 8'd1;
                end else begin
                    w_fail_count_nxt = r_fail_count;
                end
`endif
                if (w_abort || r_last) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    // A write drives Read=1/Write=1, a read drives Read=0/Write=0
                    w_read_nxt    = !w_op_rd;
                    w_write_nxt   = !w_op_rd;
                    w_addr_nxt    = r_cnt;
                    w_din_nxt     = (!w_op_rd && w_wr_bg) ? DATA_ONES : DATA_ZERO;
                    w_rd_pend_nxt = w_op_rd;
                    w_exp_bg_nxt  = w_rd_bg;
                    if (!w_sub_last) begin
                        w_sub_nxt = 1'b1;
                    end else begin
                        w_sub_nxt = 1'b0;
                        if (r_cnt == w_end_addr) begin
                            if (r_elem == 3'd5) begin
                                w_last_nxt = 1'b1;
                            end else begin
                                w_elem_nxt = w_elem_inc;
                                w_cnt_nxt  = (w_elem_inc >= 3'd3) ? ADDR_MAX : ADDR_ZERO;
                            end
                        end else if (w_down) begin
                            w_cnt_nxt = r_cnt - {{(ADDR_W-1){1'b0}}, 1'b1};
                        end else begin
                            w_cnt_nxt = r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, asynchronously forced idle by reset
    always_ff @(posedge CoreIN_CLK or posedge CoreIN_RESET) begin
        if (CoreIN_RESET) begin
            r_state     <= ST_IDLE;
            r_elem      <= 3'd0;
            r_sub       <= 1'b0;
            r_cnt       <= ADDR_ZERO;
            r_last      <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_exp_bg    <= 1'b0;
            r_read      <= 1'b1;
            r_write     <= 1'b0;
            r_addr      <= ADDR_ZERO;
            r_din       <= DATA_ZERO;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= ADDR_ZERO;
            r_fail_data <= DATA_ZERO;
`ifdef EX_CORE_MBIST_DIAG_EN
            r_fail_count <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_elem      <= w_elem_nxt;
            r_sub       <= w_sub_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_rd_pend   <= w_rd_pend_nxt;
            r_exp_bg    <= w_exp_bg_nxt;
            r_read      <= w_read_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_din       <= w_din_nxt;
            r_done      <= w_done_nxt;
            r_fail      <= w_fail_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_data <= w_fail_data_nxt;
`ifdef EX_CORE_MBIST_DIAG_EN
            r_fail_count <= w_fail_count_nxt;
`endif
        end
    end

    assign Read        = r_read;
    assign Write       = r_write;
    assign CoreIN_ADDR = r_addr;
    assign CoreIN_DIN  = r_din;
    assign bist_done   = r_done;
    assign bist_fail   = r_fail;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
`ifdef EX_CORE_MBIST_DIAG_EN
    assign fail_count  = r_fail_count;
`endif

endmodule

// File: doc/ex_core_mbist.md
EX_CORE_MBIST -- requirements
Module: ex_core_mbist

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the RAM address width; the test covers 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 8, SHALL set the RAM data width.
REQ-003 CoreIN_CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 CoreIN_RESET  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 bist_start  input  1  SHALL request a test run; sampled only in IDLE or DONE.
REQ-006 CoreIN_DOUT  input  DATA_W  SHALL carry RAM read data.
REQ-007 Read  output  1  SHALL be the RAM read/write-qualify strobe.
REQ-008 Write  output  1  SHALL be the RAM write strobe.
REQ-009 CoreIN_ADDR  output  ADDR_W  SHALL be the RAM address.
REQ-010 CoreIN_DIN  output  DATA_W  SHALL be the RAM write data.
REQ-011 bist_done  output  1  SHALL flag test completion.
REQ-012 bist_fail  output  1  SHALL flag at least one read mismatch.
REQ-013 fail_addr  output  ADDR_W  SHALL hold the address of the first mismatch.
REQ-014 fail_data  output  DATA_W  SHALL hold the data read at the first mismatch.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 RAM pin encoding SHALL be: idle Read=1/Write=0; write Read=1/Write=1; read Read=0/Write=0; Read=0/Write=1 SHALL never be driven.
REQ-017 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN and DONE->RUN on bist_start=1; RUN->DONE after the final compare; bist_start SHALL be ignored in RUN.
REQ-018 RUN SHALL execute March C- with background 0=all-zeros, 1=all-ones: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 down(r0).
REQ-019 Each operation SHALL occupy exactly one clock cycle on the RAM pins; one full run SHALL be 10*2^ADDR_W op cycles (640 at defaults).
REQ-020 "Up" SHALL count address 0 to 2^ADDR_W-1; "down" SHALL count 2^ADDR_W-1 to 0; address wrap between elements SHALL not generate extra cycles.
REQ-021 CoreIN_DOUT SHALL be compared with expected data on the clock edge that ends each read cycle.
REQ-022 bist_start=1 sampled at edge N SHALL put the first op on the pins from edge N+1; at defaults bist_done SHALL rise at edge N+641.
REQ-023 On the first mismatch of a run, bist_fail SHALL be set and fail_addr/fail_data captured; later mismatches SHALL not overwrite them.
REQ-024 In DONE, pins SHALL be idle and bist_done, bist_fail, fail_addr, fail_data SHALL hold until the next start.
REQ-025 A start from DONE SHALL clear bist_done, bist_fail, fail_addr, fail_data on the same edge it enters RUN.

Reset
REQ-026 CoreIN_RESET=1 SHALL immediately force IDLE, Read=1, Write=0, CoreIN_ADDR=0, CoreIN_DIN=0, bist_done=0, bist_fail=0, fail_addr=0, fail_data=0, including mid-run.
REQ-027 After reset release, the block SHALL stay in IDLE until bist_start=1 is sampled.

Configuration
REQ-028 Macro EX_CORE_MBIST_DIAG_EN defined: the run SHALL continue after mismatches to the end, and extra output fail_count (8 bits, reset 0, cleared on start) SHALL count mismatches, saturating at 255.
REQ-029 Macro EX_CORE_MBIST_DIAG_EN undefined: fail_count SHALL not exist, and the first mismatch SHALL end the run; bist_fail and bist_done rise on that compare edge, and the FSM enters DONE with pins idle.

Verification
REQ-030 Fault-free 64x8 RAM model, start at edge N -> bist_done=1 at edge N+641, bist_fail=0, no Read=0/Write=1 cycle observed.
REQ-031 Addr 0x2A bit0 stuck-at-1 without DIAG -> bist_fail=1 and bist_done=1 on the M1 r0 compare at 0x2A; fail_addr=0x2A, fail_data=0x01.
REQ-032 Same fault with EX_CORE_MBIST_DIAG_EN -> bist_done at edge N+641, fail_addr=0x2A, fail_data=0x01, fail_count=3.
REQ-033 Assert CoreIN_RESET at op cycle 300 -> pins idle (Read=1, Write=0, ADDR=0) and all flags 0 with no clock edge needed; no activity until a new start.
REQ-034 Pulse bist_start during RUN -> run length unchanged at 640 op cycles; restart from DONE after a failing run -> bist_fail cleared on entry to RUN, and a fault-free RAM then passes.
